// File: rtl/truth_table_scanner.sv
// truth_table_scanner: drives {x,y,z} through 000..111, samples the
// expression output s once per combination after SETTLE cycles, and
// publishes the captured truth table, its minterm count and a compare
// against an expected table latched when the sweep is accepted.
module truth_table_scanner #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       s,
  input  logic [7:0] expected,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [3:0] ones,
  output logic       match,
  output logic [3:0] first_miss
);

  // Hold count per vector; 0 behaves as 1, anything above 15 saturates
  // so the 4-bit counter can always represent it.
  localparam int         SETTLE_EFF = (SETTLE < 1) ? 1 : ((SETTLE > 15) ? 15 : SETTLE);
  localparam logic [3:0] RELOAD     = 4'(SETTLE_EFF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] idx;       // current combination index, mirrors {x,y,z} in RUN
  logic [3:0] cnt;       // edges left before the current vector is sampled
  logic [7:0] exp_q;     // expected table captured at start acceptance
  logic [7:0] shadow;    // in-flight capture; result only moves at DONE
  logic [3:0] ones_acc;  // minterms captured so far this sweep

  logic       expire;
  logic [7:0] sample_tbl;
  logic [7:0] miss;
  logic [3:0] ones_next;
  logic [3:0] fm_next;

  assign expire = (cnt == 4'd1);

  // Shadow table as it stands after folding in the current sample, so the
  // last vector's sample is visible on the same edge that publishes results.
  always_comb begin
    sample_tbl      = shadow;
    sample_tbl[idx] = s;
  end

  assign miss      = sample_tbl ^ exp_q;
  assign ones_next = ones_acc + {3'd0, s};

  // Lowest mismatching index, 8 when the tables agree.
  always_comb begin
    fm_next = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (miss[i]) fm_next = 4'(i);
    end
  end

  // Sweep controller: single FSM owning stimulus, capture and results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= 3'd0;
      cnt        <= 4'd0;
      exp_q      <= 8'h00;
      shadow     <= 8'h00;
      ones_acc   <= 4'd0;
      x          <= 1'b0;
      y          <= 1'b0;
      z          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= 8'h00;
      ones       <= 4'd0;
      match      <= 1'b0;
      first_miss <= 4'd15;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            idx       <= 3'd0;
            {x, y, z} <= 3'b000;
            cnt       <= RELOAD;
            exp_q     <= expected;
            shadow    <= 8'h00;
            ones_acc  <= 4'd0;
            busy      <= 1'b1;
            state     <= S_RUN;
          end
        end

        S_RUN: begin
          if (expire) begin
            shadow   <= sample_tbl;
            ones_acc <= ones_next;
            if (idx != 3'd7) begin
              idx       <= idx + 3'd1;
              {x, y, z} <= idx + 3'd1;
              cnt       <= RELOAD;
            end else begin
              result     <= sample_tbl;
              ones       <= ones_next;
              first_miss <= fm_next;
              match      <= (fm_next == 4'd8);
              done       <= 1'b1;
              busy       <= 1'b0;
              {x, y, z}  <= 3'b000;
              state      <= S_DONE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        // One-cycle result strobe; start is deliberately ignored here.
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
